preemph_framer: RTL and testbench
=================================

# preemph_framer

Downstream stage of the audio sample source. Accepts the 16-bit signed sample stream, optionally applies a first-order pre-emphasis filter, and stores the result in a ring buffer. It then emits overlapping fixed-length frames on a valid/ready stream for the windowing/FFT feature-extraction chain. Frames advance by HOP samples; consecutive frames share FRAME_LEN−HOP samples.

## Interface
- FRAME_LEN, 256: samples per frame; power of two, ≥ 4.
- HOP, 128: frame advance in samples; power of two, ≤ FRAME_LEN.
- DEPTH, 2*FRAME_LEN: ring buffer depth in samples; power of two.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a sample.
- in_data  in  16  signed sample.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  out_data holds a frame sample.
- out_data  out  16  signed (pre-emphasised) frame sample.
- out_ready  in  1  consumer accepts the sample this cycle.
- out_last  out  1  high on the final sample of a frame (index FRAME_LEN−1).
- out_index  out  log2(FRAME_LEN)  position of out_data within its frame.
- frame_cnt  out  16  number of frames fully emitted; wraps at 65535→0.

## Operation
- Input accept: in_valid && in_ready at a posedge. in_ready = (occupancy < DEPTH) and is forced low while rst is low.
- Occupancy = samples written but not yet retired; range 0..DEPTH.
- Pre-emphasis, per accepted sample: y = x − x_prev + (x_prev >>> 5), i.e. α = 31/32.
  - Compute in 18-bit signed arithmetic; saturate to [−32768, 32767].
  - x_prev ← x on each accept; x_prev = 0 after reset.
- y is written at wr_ptr; wr_ptr increments modulo DEPTH.
- FSM states:
  - IDLE → LOAD when occupancy ≥ FRAME_LEN.
  - LOAD: issue the read at frame_start; registered RAM, 1-cycle latency. → EMIT.
  - EMIT: prefetch keeps one sample per cycle flowing while out_ready is high.
  - Last-sample handshake (out_last && out_ready): frame_start += HOP (mod DEPTH), occupancy −= HOP, frame_cnt += 1. Then → LOAD if occupancy (after update) ≥ FRAME_LEN, else → IDLE.
- Simultaneous accept and retire in one cycle: occupancy += 1 − HOP.
- out_data, out_index and out_last are held stable while out_valid && !out_ready.
- Buffer full (occupancy == DEPTH): in_ready = 0. Input is stalled, never dropped.
- Reset mid-operation clears all state:
  - pointers, occupancy, x_prev and frame_cnt go to 0; FSM → IDLE;
  - the partial frame is discarded.

## Timing
- Reset values: in_ready 0 while asserted, 1 in the first cycle after release; out_valid 0, out_data 0, out_last 0, out_index 0, frame_cnt 0.
- First out_valid of a frame asserts exactly 2 cycles after the edge that accepted the FRAME_LEN-th sample, provided the FSM was in IDLE.
- Throughput: 1 sample/cycle on output while out_ready = 1. A frame with no stalls takes FRAME_LEN cycles.
- Inter-frame gap: 1 bubble cycle (LOAD) between out_last handshake and the next out_valid, if the next frame is already available.
- in_ready responds combinationally to occupancy. An accept in the same cycle a retire frees space is legal.

## Configuration
- PREEMPH_EN defined: pre-emphasis filter as above.
- PREEMPH_EN undefined: y = x (pass-through). x_prev logic and saturation are not synthesised. Framing behaviour is identical.

## Test plan
- PREEMPH_EN off, reset, ramp 0..511, out_ready = 1:
  - frame 0 = 0..255, frame 1 = 128..383, frame 2 = 256..511;
  - out_last only at out_index 255;
  - frame_cnt = 3 after the third out_last.
- PREEMPH_EN on, constant input 1024 → first output 1024, all later outputs 32.
- PREEMPH_EN on, input −32768 then 32767 → second output saturates to 32767. Input 32767 then −32768 → −32768.
- out_ready = 0, 600 samples offered:
  - in_ready falls after 512 accepts; samples 513+ stall.
  - Raise out_ready: frames continue with no lost or duplicated samples.
  - in_ready rises the cycle after frame 0 retires.
- Random out_ready (50%) with a continuous ramp: output order matches the reference model; data is held stable during stalls.
- Drop rst low mid-frame 1 (out_index 100), then release and feed a new ramp from 1000:
  - all outputs are 0 during reset;
  - the first frame after reset starts at 1000 (pass-through), with x_prev = 0 for pre-emphasis.

Source files
------------

// File: rtl/preemph_framer.sv
// preemph_framer
//   Takes a 16-bit signed sample stream, optionally pre-emphasises it
//   (y = x - x_prev + (x_prev >>> 5), saturated to 16 bits), stores the result in a
//   ring buffer and replays it as overlapping frames of FRAME_LEN samples that
//   advance by HOP samples.
//
//   Build option: define PREEMPH_EN to enable the pre-emphasis filter; when it is
//   undefined samples pass through unchanged and the filter state is not built.
//
//   Ports
//     clk        sole clock, rising edge
//     rst        asynchronous reset, active low
//     in_valid   in_data holds a sample
//     in_data    signed input sample
//     in_ready   a sample can be accepted this cycle (buffer not full, not in reset)
//     out_valid  out_data holds a frame sample
//     out_data   signed (pre-emphasised) frame sample
//     out_ready  consumer takes the sample this cycle
//     out_last   final sample of the frame
//     out_index  position of out_data within its frame
//     frame_cnt  frames fully emitted, wraps at 16 bits
module preemph_framer #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned HOP       = 128,
    parameter int unsigned DEPTH     = 2 * FRAME_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [15:0]                  in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [15:0]                  out_data,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [$clog2(FRAME_LEN)-1:0] out_index,
    output logic [15:0]                  frame_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = $clog2(FRAME_LEN);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [OW-1:0] FL_C    = OW'(FRAME_LEN);
    localparam logic [OW-1:0] HOP_C   = OW'(HOP);
    localparam logic [IW-1:0] LAST_C  = IW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] frame_start_q, frame_start_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   rd_data_q, rd_data_d;

    logic [15:0]   mem [DEPTH];

    logic          accept;
    logic          retire;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   wr_data;

    // ------------------------------------------------------------------
    // Sample conditioning
    // ------------------------------------------------------------------
`ifdef PREEMPH_EN
    logic signed [15:0] x_prev_q, x_prev_d;
    logic signed [17:0] y_wide;

    always_comb begin
        // 18 bits hold the full range of x - x_prev + x_prev/32 without overflow
        y_wide = 18'(signed'(in_data)) - 18'(x_prev_q) + 18'(x_prev_q >>> 5);
        if (y_wide > 18'sd32767) begin
            wr_data = 16'h7FFF;
        end else if (y_wide < -18'sd32768) begin
            wr_data = 16'h8000;
        end else begin
            wr_data = y_wide[15:0];
        end
        x_prev_d = accept ? signed'(in_data) : x_prev_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_prev_q <= '0;
        end else begin
            x_prev_q <= x_prev_d;
        end
    end
`else
    always_comb begin
        wr_data = in_data;
    end
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign in_ready  = rst && (occ_q < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign out_data  = rd_data_q;
    assign out_index = idx_q;
    assign frame_cnt = frame_cnt_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (occ_q >= FL_C) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_EMIT;
            ST_EMIT: if (retire) state_d = (occ_d >= FL_C) ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and read-port control
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q == ST_EMIT);
        out_last  = out_valid && (idx_q == LAST_C);
        retire    = out_valid && out_ready && out_last;
        rd_en     = 1'b0;
        rd_addr   = frame_start_q;
        case (state_q)
            ST_LOAD: rd_en = 1'b1;
            ST_EMIT: begin
                // Fetch the next sample only when the current one is taken, so a
                // stalled consumer sees out_data held without a skid register.
                if (out_ready && !out_last) begin
                    rd_en   = 1'b1;
                    rd_addr = frame_start_q + AW'(idx_q) + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        rd_data_d     = rd_data_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        // Accept and retire in the same cycle net to +1 - HOP.
        occ_d = occ_q + OW'(accept) - (retire ? HOP_C : '0);

        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end

        if (state_q == ST_LOAD) begin
            idx_d = '0;
        end else if (out_valid && out_ready) begin
            idx_d = out_last ? '0 : idx_q + IW'(1);
        end

        if (retire) begin
            frame_start_d = frame_start_q + AW'(HOP);
            frame_cnt_d   = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            frame_start_q <= '0;
            occ_q         <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            rd_data_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            frame_start_q <= frame_start_d;
            occ_q         <= occ_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Sample storage; contents need no reset since only written entries are read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_preemph_framer.sv
module tb_preemph_framer;

    localparam int FL    = 256;
    localparam int HOP   = 128;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [7:0]  out_index;
    logic [15:0] frame_cnt;

    preemph_framer #(.FRAME_LEN(FL), .HOP(HOP), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: every accepted (conditioned) sample in arrival order.
    // Frame k is ys[k*HOP +: FL]; base is the first sample of the current frame.
    logic [15:0] ys[$];
    int base, pos, frames, xprev, cyc;
    int gap1_cyc, gap2_cyc, gap2_exp, lat_cyc, lat_early_cyc;
    logic        last_acc;
    logic [15:0] cap [6];
    logic [15:0] exp6 [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_y(input logic signed [15:0] x);
`ifdef PREEMPH_EN
        int v;
        v = int'(x) - xprev + (xprev >>> 5);
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        xprev = int'(x);
        return 16'(v);
`else
        return x;
`endif
    endfunction

    task automatic model_reset();
        ys.delete();
        base = 0; pos = 0; frames = 0; xprev = 0;
        gap1_cyc = -1; gap2_cyc = -1; gap2_exp = 0;
        lat_cyc = -1; lat_early_cyc = -1;
        for (int k = 0; k < 6; k++) cap[k] = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"},  32'(out_data), 0);
        chk({tag, "_out_last"},  32'(out_last), 0);
        chk({tag, "_out_index"}, 32'(out_index), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_zero_outputs("rst");
        @(posedge clk); #1;
        check_zero_outputs("rst_hold");
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        model_reset();
    endtask

    // One clock cycle: check DUT outputs against the model, update the model with
    // the handshakes that the coming edge will perform, then advance the clock.
    task automatic step();
        int occ, i;
        logic acc;
        occ = ys.size() - base;
        chk("in_ready", 32'(in_ready), 32'(occ < DEPTH));
        chk("frame_cnt", 32'(frame_cnt), 32'(16'(frames)));
        if (cyc == gap1_cyc)      chk("load_bubble", 32'(out_valid), 0);
        if (cyc == gap2_cyc)      chk("next_frame_start", 32'(out_valid), 32'(gap2_exp));
        if (cyc == lat_early_cyc) chk("first_valid_early", 32'(out_valid), 0);
        if (cyc == lat_cyc)       chk("first_valid_latency", 32'(out_valid), 1);
        if (out_valid === 1'b1) begin
            i = base + pos;
            chk("out_avail", 32'(i < ys.size()), 1);
            if (i < ys.size()) begin
                chk("out_data",  {16'h0, out_data}, {16'h0, ys[i]});
                chk("out_index", 32'(out_index), 32'(pos));
                chk("out_last",  32'(out_last), 32'(pos == FL - 1));
            end
        end

        acc = in_valid && (occ < DEPTH);
        last_acc = acc;
        if (acc) begin
            ys.push_back(model_y(in_data));
            if (frames == 0 && ys.size() == FL) begin
                lat_early_cyc = cyc + 2;
                lat_cyc       = cyc + 3;
            end
        end
        if (out_valid === 1'b1 && out_ready) begin
            if (frames == 0 && pos < 6) cap[pos] = out_data;
            pos++;
            if (pos == FL) begin
                pos = 0;
                base += HOP;
                frames++;
                gap1_cyc = cyc + 1;
                gap2_cyc = cyc + 2;
                gap2_exp = int'((ys.size() - base) >= FL);
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        int v, n_acc, exp_frames;
        cyc = 0;
        model_reset();
`ifdef PREEMPH_EN
        exp6 = '{16'd1024, 16'd32, 16'd32, 16'h8000, 16'h7FFF, 16'h8000};
`else
        exp6 = '{16'd1024, 16'd1024, 16'd1024, 16'h8000, 16'h7FFF, 16'h8000};
`endif
        #2;

        // Ramp 0..511 with a ready consumer: three frames, then nothing more.
        apply_reset();
        out_ready = 1'b1;
        v = 0;
        for (int n = 0; n < 3000 && frames < 3; n++) begin
            in_valid = (v < 512);
            in_data  = 16'(v);
            step();
            if (last_acc) v++;
        end
        chk("ramp_frame_cnt", 32'(frame_cnt), 3);
        chk("ramp_accepted", 32'(v), 512);
        in_valid = 1'b0;
        for (int n = 0; n < 20; n++) step();
        chk("ramp_no_fourth_frame", 32'(out_valid), 0);

        // Saturation corners and constant input.
        apply_reset();
        out_ready = 1'b1;
        v = 0;
        for (int n = 0; n < 1000 && frames < 1; n++) begin
            in_valid = (v < FL);
            case (v)
                0, 1, 2: in_data = 16'd1024;
                3:       in_data = 16'h8000;
                4:       in_data = 16'h7FFF;
                5:       in_data = 16'h8000;
                default: in_data = 16'd0;
            endcase
            step();
            if (last_acc) v++;
        end
        for (int k = 0; k < 6; k++)
            chk($sformatf("sat_seq[%0d]", k), {16'h0, cap[k]}, {16'h0, exp6[k]});

        // Back-pressure: consumer stalled while 600 samples are offered.
        apply_reset();
        out_ready = 1'b0;
        v = 0;
        for (int n = 0; n < 700; n++) begin
            in_valid = (v < 600);
            in_data  = 16'(v + 5000);
            step();
            if (last_acc) v++;
        end
        chk("stall_accepts", 32'(v), 512);
        chk("stall_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        for (int n = 0; n < 3000 && !(frames == 3 && v == 600); n++) begin
            in_valid = (v < 600);
            in_data  = 16'(v + 5000);
            step();
            if (last_acc) v++;
        end
        chk("stall_frames", 32'(frame_cnt), 3);
        chk("stall_all_accepted", 32'(v), 600);

        // Random consumer readiness, ramp then random data with random gaps.
        apply_reset();
        v = 0;
        for (int n = 0; n < 2000; n++) begin
            out_ready = 1'($urandom % 2);
            in_valid  = 1'b1;
            in_data   = 16'(v);
            step();
            if (last_acc) v++;
        end
        for (int n = 0; n < 2000; n++) begin
            out_ready = 1'($urandom % 2);
            in_valid  = 1'($urandom % 2);
            in_data   = 16'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) step();
        n_acc = ys.size();
        exp_frames = (n_acc >= FL) ? (n_acc - FL) / HOP + 1 : 0;
        chk("random_drain_frames", 32'(frame_cnt), 32'(exp_frames));

        // Reset in the middle of frame 1, then a fresh ramp from 1000.
        apply_reset();
        out_ready = 1'b1;
        v = 0;
        for (int n = 0; n < 2000 && !(frames == 1 && pos == 100); n++) begin
            in_valid = 1'b1;
            in_data  = 16'(v);
            step();
            if (last_acc) v++;
        end
        chk("reached_mid_frame", 32'(out_index), 100);
        apply_reset();
        v = 0;
        for (int n = 0; n < 1000 && frames < 1; n++) begin
            in_valid = (v < FL);
            in_data  = 16'(1000 + v);
            step();
            if (last_acc) v++;
        end
        chk("post_reset_first_sample", {16'h0, cap[0]}, 32'd1000);
        chk("post_reset_frame_cnt", 32'(frame_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
